// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply unit.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int CNT_W     = $clog2(MUL_WIDTH);

    localparam logic MUL_TYPE_MUL  = 1'b0;
    localparam logic MUL_TYPE_LONG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_abs.sv
// Combinational conditional two's-complement negate.
module mul_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL, UMULL and SMULL.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             opMul,
    input  logic             IsLongMul,
    input  logic             Signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int CW = (WIDTH == MUL_WIDTH) ? CNT_W : $clog2(WIDTH);

    mul_state_t       state;
    logic             long_mode;
    logic             neg;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_fin;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             sgn_in;
    logic             flag_n;
    logic             flag_z;

    assign sgn_in = IsLongMul & Signed;

    mul_abs #(.W(WIDTH)) u_abs_a (
        .value  (SrcA),
        .negate (sgn_in & SrcA[WIDTH-1]),
        .result (abs_a)
    );

    mul_abs #(.W(WIDTH)) u_abs_b (
        .value  (SrcB),
        .negate (sgn_in & SrcB[WIDTH-1]),
        .result (abs_b)
    );

    mul_abs #(.W(2*WIDTH)) u_abs_res (
        .value  (acc),
        .negate (neg),
        .result (acc_fin)
    );

    always_comb begin
        // Carry out of the upper-half add becomes the bit shifted in at the top.
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        if (long_mode == MUL_TYPE_LONG) begin
            flag_n = acc_fin[2*WIDTH-1];
            flag_z = (acc_fin == '0);
        end else begin
            flag_n = acc_fin[WIDTH-1];
            flag_z = (acc_fin[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ResultLo  <= '0;
            ResultHi  <= '0;
            MulFlags  <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            long_mode <= MUL_TYPE_MUL;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && opMul) begin
                        long_mode <= IsLongMul;
                        neg       <= sgn_in & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        mcand     <= abs_a;
                        mplier    <= abs_b;
                        acc       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    ResultLo <= acc_fin[WIDTH-1:0];
                    ResultHi <= (long_mode == MUL_TYPE_MUL) ? '0 : acc_fin[2*WIDTH-1:WIDTH];
                    MulFlags <= {flag_n, flag_z};
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
